cr_kme_fifo_arb: RTL and testbench

CR_KME_FIFO_ARB -- requirements
Module: cr_kme_fifo_arb

---
 rtl/cr_kme_fifo_arb.sv | 103 ++++++++++
 tb/tb_cr_kme_fifo_arb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cr_kme_fifo_arb.sv
// Round-robin arbiter that merges N_REQ packet streams onto one KME FIFO write port.
// A requester keeps the port from its first beat through its eop beat.
module cr_kme_fifo_arb #(
  parameter int N_REQ     = 4,
  parameter int DATA_SIZE = 64,
  localparam int OW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_SIZE-1:0] req_data,
  input  logic [N_REQ-1:0]           req_eop,
  output logic [N_REQ-1:0]           req_ack,
  output logic [DATA_SIZE-1:0]       fifo_in,
  output logic                       fifo_in_valid,
  input  logic                       fifo_in_stall,
  output logic [OW-1:0]              owner,
  output logic                       locked,
  output logic [15:0]                pkt_cnt
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [OW-1:0]        rr_ptr;
  logic [OW-1:0]        scan_idx;
  logic                 scan_hit;
  logic [OW-1:0]        grant_idx;
  logic                 grant_any;
  logic                 ack;
  logic                 beat_eop;
  logic [DATA_SIZE-1:0] beat_data;
  logic [OW-1:0]        next_rr;

  // first valid requester at or above rr_ptr, wrapping
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!scan_hit && req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
        scan_hit = 1'b1;
        scan_idx = OW'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    grant_idx = (state == LOCKED) ? owner : scan_idx;
    grant_any = (state == LOCKED) | scan_hit;
    ack       = grant_any & req_valid[grant_idx]
              & ~fifo_in_stall & ~rst;
    beat_eop  = req_eop[grant_idx];
    beat_data = req_data[grant_idx*DATA_SIZE +: DATA_SIZE];
    req_ack   = ack ? (N_REQ'(1) << grant_idx) : '0;
    next_rr   = (grant_idx == OW'(N_REQ - 1))
              ? '0 : grant_idx + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    if (ack) begin
      state_nxt = beat_eop ? IDLE : LOCKED;
    end
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr        <= '0;
      owner         <= '0;
      fifo_in       <= '0;
      fifo_in_valid <= 1'b0;
      pkt_cnt       <= '0;
    end else begin
      fifo_in_valid <= ack;
      if (ack) begin
        fifo_in <= beat_data;
        owner   <= grant_idx;
        if (beat_eop) begin
          rr_ptr <= next_rr;
          if (pkt_cnt != 16'hFFFF) begin
            pkt_cnt <= pkt_cnt + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cr_kme_fifo_arb.sv
// Randomized and directed bench for cr_kme_fifo_arb.
// Reference model predicts acks and state; a monitor checks FIFO writes.
module tb_cr_kme_fifo_arb;

  localparam int N = 4;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_eop = '0;
  logic [N-1:0]   req_ack;
  logic [W-1:0]   fifo_in;
  logic           fifo_in_valid;
  logic           fifo_in_stall = 1'b0;
  logic [1:0]     owner;
  logic           locked;
  logic [15:0]    pkt_cnt;

  cr_kme_fifo_arb #(.N_REQ(N), .DATA_SIZE(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_eop       (req_eop),
    .req_ack       (req_ack),
    .fifo_in       (fifo_in),
    .fifo_in_valid (fifo_in_valid),
    .fifo_in_stall (fifo_in_stall),
    .owner         (owner),
    .locked        (locked),
    .pkt_cnt       (pkt_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] expq[$];
  logic [W-1:0] last_wr = '0;

  // packet-level model: who holds the port, where the next scan starts
  bit m_locked = 1'b0;
  int m_owner  = 0;
  int m_rr     = 0;
  int m_cnt    = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [N-1:0] eack;
    int g;
    chk("locked", 64'(locked), 64'(m_locked));
    chk("owner", 64'(owner), 64'(m_owner));
    chk("pkt_cnt", 64'(pkt_cnt), 64'(m_cnt));
    eack = '0;
    g = -1;
    if (!rst && !fifo_in_stall) begin
      if (m_locked) begin
        if (req_valid[m_owner]) g = m_owner;
      end else begin
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
    end
    if (g >= 0) eack[g] = 1'b1;
    chk("req_ack", 64'(req_ack), 64'(eack));
    if (g >= 0) begin
      expq.push_back(req_data[g*W +: W]);
      m_owner = g;
      if (req_eop[g]) begin
        m_locked = 1'b0;
        m_rr = (g + 1) % N;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        m_locked = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rst) begin
      chk("rst_valid", 64'(fifo_in_valid), 64'd0);
      chk("rst_data", fifo_in, 64'd0);
      last_wr = '0;
    end else if (fifo_in_valid) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_write actual=%0h required=none at %0t",
                 fifo_in, $time);
      end else begin
        chk("fifo_in", fifo_in, expq.pop_front());
      end
      last_wr = fifo_in;
    end else begin
      chk("fifo_hold", fifo_in, last_wr);
      if (expq.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL missing_write actual=none required=%0h at %0t",
                 expq[0], $time);
        expq.delete();
      end
    end
  end

  task automatic step(input logic [N-1:0] v, input logic [N-1:0] e,
                      input logic s);
    req_valid = v;
    req_eop = e;
    fifo_in_stall = s;
    for (int i = 0; i < N; i++)
      req_data[i*W +: W] = {$urandom, $urandom};
    @(posedge clk);
    #1;
  endtask

  // reset lands after the negedge ack, so that beat must never be written
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    expq.delete();
    m_locked = 1'b0;
    m_owner = 0;
    m_rr = 0;
    m_cnt = 0;
    #1;
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_fvalid", 64'(fifo_in_valid), 64'd0);
    chk("rst_ack", 64'(req_ack), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // all valid single-beat packets rotate 0,1,2,3
    repeat (4) step(4'b1111, 4'b1111, 1'b0);
    repeat (2) step(4'b0000, 4'b0000, 1'b0);
    chk("pkt_cnt_4", 64'(pkt_cnt), 64'd4);

    // req 1 three-beat packet with 0 and 2 contending
    step(4'b0010, 4'b0000, 1'b0);
    chk("locked_r1", 64'(locked), 64'd1);
    step(4'b0111, 4'b0000, 1'b0);
    step(4'b0111, 4'b0010, 1'b0);
    chk("unlock_r1", 64'(locked), 64'd0);
    step(4'b0101, 4'b0101, 1'b0);
    chk("next_is_2", 64'(owner), 64'd2);
    step(4'b0000, 4'b0000, 1'b0);

    // stall in the middle of a packet
    step(4'b0001, 4'b0000, 1'b0);
    repeat (3) step(4'b0011, 4'b0000, 1'b1);
    step(4'b0011, 4'b0000, 1'b0);
    step(4'b0011, 4'b0001, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);

    // owner 3 goes quiet while others wait
    step(4'b1000, 4'b0000, 1'b0);
    repeat (5) step(4'b0111, 4'b0000, 1'b0);
    chk("hold_lock", 64'(locked), 64'd1);
    step(4'b1111, 4'b0000, 1'b0);

    // reset while locked to 3; regrant to 3 from a scan at 0
    do_reset();
    step(4'b1000, 4'b1000, 1'b0);
    chk("regrant_3", 64'(owner), 64'd3);
    repeat (2) step(4'b0000, 4'b0000, 1'b0);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      step(N'($urandom), ($urandom_range(0, 2) == 0) ? N'($urandom) : '0,
           $urandom_range(0, 4) == 0);
    end
    repeat (2) step(4'b0000, 4'b0000, 1'b0);

    // saturation of the packet counter
    do_reset();
    repeat (65540) step(4'b1111, 4'b1111, 1'b0);
    repeat (3) step(4'b0000, 4'b0000, 1'b0);
    chk("pkt_cnt_sat", 64'(pkt_cnt), 64'hFFFF);
    chk("queue_empty", 64'(expq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
